fp_absmax_reduce: RTL and testbench

- Stream reduction controller that sequences one shared `abs_comparator` instance to find the largest-magnitude element of a vector.
- Vectors are FP32 or FP16x2 packed words, delivered as beats over valid/ready and terminated by `in_last`.
- Maintains a running max-|x| accumulator and the winning element index per lane, then presents the result on a valid/ready output.
- Sits between the vector load unit and the FP normalisation/scaling logic, e.g. for amax computation before quantisation.

---
 rtl/fp_absmax_reduce.sv | 214 +++++++++++++++++++++
 tb/tb_fp_absmax_reduce.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_absmax_reduce.sv
// Streaming max-|x| reduction over FP32 / FP16x2 vectors using one shared combinational comparator.
// Optional FP_ABSMAX_NAN_EN: sticky per-lane NaN tracking with canonical qNaN on the result.

module abs_comparator (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        fmt,
    output logic        swap_h,
    output logic        swap_l
);

    // Sign bits are ignored so the compare is on magnitude only.
    // FP32 uses bit 15 as mantissa, but the FP16 hi sign bit is never needed.
    logic sign_unused;
    assign sign_unused = x[31] ^ y[31];

    // Strict greater-than keeps the earlier element on ties.
    always_comb begin
        swap_h = 1'b0;
        swap_l = 1'b0;
        if (fmt) begin
            swap_h = (y[30:16] > x[30:16]);
            swap_l = (y[14:0]  > x[14:0]);
        end else begin
            swap_h = (y[30:0] > x[30:0]);
        end
    end

endmodule

module fp_absmax_reduce #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_fmt,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_fmt,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_idx_hi,
    output logic [IDX_W-1:0] out_idx_lo,
    output logic             out_fmt_err,
    output logic             out_ovf
);

    localparam logic       FMT_FP32 = 1'b0;
    localparam logic       FMT_FP16 = 1'b1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [31:0]      acc;
    logic             fmt;
    logic [IDX_W-1:0] idx_hi;
    logic [IDX_W-1:0] idx_lo;
    logic [IDX_W-1:0] cnt;
    logic             fmt_err;
    logic             ovf;

    logic accept;
    logic fmt_ok;
    logic swap_h;
    logic swap_l;
    logic set_nan_hi;
    logic set_nan_lo;
    logic hi_frozen;
    logic lo_frozen;
    logic in_nan_hi;
    logic in_nan_lo;

    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign accept    = in_valid && in_ready;
    assign fmt_ok    = (in_fmt == fmt);
    assign out_valid = (state == DONE);

    abs_comparator u_cmp (
        .x      (acc),
        .y      (in_data),
        .fmt    (fmt),
        .swap_h (swap_h),
        .swap_l (swap_l)
    );

    // NaN classification of the incoming beat, using the beat's own format.
    always_comb begin
        in_nan_hi = 1'b0;
        in_nan_lo = 1'b0;
        if (in_fmt == FMT_FP32) begin
            in_nan_hi = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
        end else begin
            in_nan_hi = (in_data[30:26] == 5'h1F) && (in_data[25:16] != 10'd0);
            in_nan_lo = (in_data[14:10] == 5'h1F) && (in_data[9:0]   != 10'd0);
        end
    end

`ifdef FP_ABSMAX_NAN_EN
    logic nan_hi;
    logic nan_lo;

    assign hi_frozen  = nan_hi;
    assign lo_frozen  = nan_lo;
    assign set_nan_hi = !nan_hi && in_nan_hi;
    assign set_nan_lo = !nan_lo && in_nan_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_hi <= 1'b0;
            nan_lo <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                nan_hi <= in_nan_hi;
                nan_lo <= in_nan_lo;
            end else if (fmt_ok) begin
                if (set_nan_hi) nan_hi <= 1'b1;
                if (set_nan_lo) nan_lo <= 1'b1;
            end
        end
    end

    // A flagged lane reports canonical quiet NaN regardless of what acc holds.
    always_comb begin
        out_data = acc;
        if (nan_hi) begin
            if (fmt == FMT_FP32) out_data = 32'h7FC0_0000;
            else                 out_data[31:16] = 16'h7E00;
        end
        if (nan_lo && (fmt == FMT_FP16)) out_data[15:0] = 16'h7E00;
    end
`else
    logic nan_unused;

    assign nan_unused = in_nan_hi ^ in_nan_lo;
    assign hi_frozen  = 1'b0;
    assign lo_frozen  = 1'b0;
    assign set_nan_hi = 1'b0;
    assign set_nan_lo = 1'b0;
    assign out_data   = acc;
`endif

    assign out_fmt     = fmt;
    assign out_idx_hi  = idx_hi;
    assign out_idx_lo  = idx_lo;
    assign out_fmt_err = fmt_err;
    assign out_ovf     = ovf;

    // Main reduction FSM: first beat seeds the accumulator, later beats compete against it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= 32'd0;
            fmt     <= FMT_FP32;
            idx_hi  <= '0;
            idx_lo  <= '0;
            cnt     <= '0;
            fmt_err <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc     <= in_data;
                        fmt     <= in_fmt;
                        idx_hi  <= '0;
                        idx_lo  <= '0;
                        cnt     <= CNT_ONE;
                        fmt_err <= 1'b0;
                        ovf     <= 1'b0;
                        state   <= in_last ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + CNT_ONE;
                        if (!fmt_ok) begin
                            fmt_err <= 1'b1;
                        end else begin
                            if (fmt == FMT_FP32) begin
                                if (swap_h) acc <= in_data;
                            end else begin
                                if (swap_h) acc[31:16] <= in_data[31:16];
                                if (swap_l) acc[15:0]  <= in_data[15:0];
                            end
                            if (set_nan_hi || (swap_h && !hi_frozen)) idx_hi <= cnt;
                            if ((fmt == FMT_FP16) && (set_nan_lo || (swap_l && !lo_frozen)))
                                idx_lo <= cnt;
                        end
                        // The beat at the last index that fits closes the vector even without in_last.
                        if (in_last) begin
                            state <= DONE;
                        end else if (cnt == CNT_MAX) begin
                            state <= DONE;
                            ovf   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_absmax_reduce.sv
// Directed self-checking bench for fp_absmax_reduce; a second instance with IDX_W=2 covers overflow.
`timescale 1ns/1ps

module tb_fp_absmax_reduce;

    localparam logic FP32 = 1'b0;
    localparam logic FP16 = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_fmt = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_fmt;
    logic [31:0] out_data;
    logic [7:0]  out_idx_hi;
    logic [7:0]  out_idx_lo;
    logic        out_fmt_err;
    logic        out_ovf;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic        s_in_fmt = 1'b0;
    logic [31:0] s_in_data = 32'd0;
    logic        s_in_last = 1'b0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic        s_out_fmt;
    logic [31:0] s_out_data;
    logic [1:0]  s_out_idx_hi;
    logic [1:0]  s_out_idx_lo;
    logic        s_out_fmt_err;
    logic        s_out_ovf;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fp_absmax_reduce #(.IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt),
        .out_data(out_data), .out_idx_hi(out_idx_hi), .out_idx_lo(out_idx_lo),
        .out_fmt_err(out_fmt_err), .out_ovf(out_ovf)
    );

    fp_absmax_reduce #(.IDX_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_fmt(s_in_fmt),
        .in_data(s_in_data), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_fmt(s_out_fmt),
        .out_data(s_out_data), .out_idx_hi(s_out_idx_hi), .out_idx_lo(s_out_idx_lo),
        .out_fmt_err(s_out_fmt_err), .out_ovf(s_out_ovf)
    );

    // Present one beat and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send_beat(input logic f, input logic [31:0] d, input logic l);
        int waited = 0;
        in_valid = 1'b1; in_fmt = f; in_data = d; in_last = l;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            total++;
            $display("[TB] FAIL send_beat_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_beat_small(input logic f, input logic [31:0] d);
        int waited = 0;
        s_in_valid = 1'b1; s_in_fmt = f; s_in_data = d; s_in_last = 1'b0;
        while (!s_in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!s_in_ready) begin
            total++;
            $display("[TB] FAIL send_small_timeout in_ready=%0b required=1", s_in_ready);
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_valid got %0b exp 0", out_valid); else passed++;
        total++; if (out_data !== 32'd0) $display("[TB] FAIL rst_data got %h exp 00000000", out_data); else passed++;
        total++; if ({out_idx_hi, out_idx_lo} !== 16'd0) $display("[TB] FAIL rst_idx got %h exp 0000", {out_idx_hi, out_idx_lo}); else passed++;
        total++; if ({out_fmt, out_fmt_err, out_ovf} !== 3'b000) $display("[TB] FAIL rst_flags got %b exp 000", {out_fmt, out_fmt_err, out_ovf}); else passed++;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_in_ready got %0b exp 1", in_ready); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fp32_max();
        send_beat(FP32, 32'h3F80_0000, 1'b0);
        send_beat(FP32, 32'hC000_0000, 1'b0);
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL fp32_early_valid got %0b exp 0", out_valid); else passed++;
        send_beat(FP32, 32'h3FC0_0000, 1'b1);
        total++; if (out_valid !== 1'b1) $display("[TB] FAIL fp32_latency got %0b exp 1", out_valid); else passed++;
        total++; if (out_data !== 32'hC000_0000) $display("[TB] FAIL fp32_data got %h exp c0000000", out_data); else passed++;
        total++; if (out_idx_hi !== 8'd1) $display("[TB] FAIL fp32_idx_hi got %0d exp 1", out_idx_hi); else passed++;
        total++; if (out_idx_lo !== 8'd0) $display("[TB] FAIL fp32_idx_lo got %0d exp 0", out_idx_lo); else passed++;
        total++; if ({out_fmt, out_fmt_err, out_ovf} !== 3'b000) $display("[TB] FAIL fp32_flags got %b exp 000", {out_fmt, out_fmt_err, out_ovf}); else passed++;
        consume();
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL fp32_consume got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_fp16_lanes();
        send_beat(FP16, {16'h3C00, 16'hC500}, 1'b0);
        send_beat(FP16, {16'hBC00, 16'h4000}, 1'b0);
        send_beat(FP16, {16'h4200, 16'h3800}, 1'b1);
        total++; if (out_data !== 32'h4200_C500) $display("[TB] FAIL fp16_data got %h exp 4200c500", out_data); else passed++;
        total++; if (out_idx_hi !== 8'd2) $display("[TB] FAIL fp16_idx_hi got %0d exp 2", out_idx_hi); else passed++;
        total++; if (out_idx_lo !== 8'd0) $display("[TB] FAIL fp16_idx_lo got %0d exp 0", out_idx_lo); else passed++;
        total++; if (out_fmt !== FP16) $display("[TB] FAIL fp16_fmt got %0b exp 1", out_fmt); else passed++;
        consume();
    endtask

    task automatic test_tie();
        send_beat(FP16, {16'h3C00, 16'h1234}, 1'b0);
        send_beat(FP16, {16'hBC00, 16'h9234}, 1'b1);
        total++; if (out_data !== 32'h3C00_1234) $display("[TB] FAIL tie_data got %h exp 3c001234", out_data); else passed++;
        total++; if ({out_idx_hi, out_idx_lo} !== 16'd0) $display("[TB] FAIL tie_idx got %h exp 0000", {out_idx_hi, out_idx_lo}); else passed++;
        consume();
    endtask

    task automatic test_back_to_back();
        send_beat(FP32, 32'h3F80_0000, 1'b1);
        in_valid = 1'b1; in_fmt = FP32; in_data = 32'h4040_0000; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000)
                $display("[TB] FAIL bp_hold%0d got valid=%0b data=%h exp 1/3f800000", i, out_valid, out_data); else passed++;
            total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready%0d got %0b exp 0", i, in_ready); else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL bp_release got valid=%0b ready=%0b exp 0/1", out_valid, in_ready); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 32'h4040_0000)
            $display("[TB] FAIL bp_next got valid=%0b data=%h exp 1/40400000", out_valid, out_data); else passed++;
        consume();
    endtask

    task automatic test_fmt_err_ovf();
        send_beat_small(FP32, 32'h3F80_0000);
        send_beat_small(FP16, 32'h7BFF_7BFF);
        send_beat_small(FP32, 32'h4000_0000);
        total++; if (s_out_valid !== 1'b0) $display("[TB] FAIL ovf_early_valid got %0b exp 0", s_out_valid); else passed++;
        send_beat_small(FP32, 32'h3F00_0000);
        total++; if (s_out_valid !== 1'b1) $display("[TB] FAIL ovf_forced_done got %0b exp 1", s_out_valid); else passed++;
        total++; if (s_out_data !== 32'h4000_0000) $display("[TB] FAIL ovf_data got %h exp 40000000", s_out_data); else passed++;
        total++; if (s_out_idx_hi !== 2'd2) $display("[TB] FAIL ovf_idx_hi got %0d exp 2", s_out_idx_hi); else passed++;
        total++; if ({s_out_fmt_err, s_out_ovf} !== 2'b11) $display("[TB] FAIL ovf_flags got %b exp 11", {s_out_fmt_err, s_out_ovf}); else passed++;
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        total++; if (s_out_valid !== 1'b0) $display("[TB] FAIL ovf_consume got %0b exp 0", s_out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        send_beat(FP32, 32'h4100_0000, 1'b0);
        send_beat(FP32, 32'hC120_0000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'd0)
            $display("[TB] FAIL rmid_out got valid=%0b data=%h exp 0/00000000", out_valid, out_data); else passed++;
        total++; if ({out_idx_hi, out_idx_lo} !== 16'd0 || in_ready !== 1'b1)
            $display("[TB] FAIL rmid_state got idx=%h ready=%0b exp 0000/1", {out_idx_hi, out_idx_lo}, in_ready); else passed++;
        send_beat(FP32, 32'h3F80_0000, 1'b1);
        total++; if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000 || out_idx_hi !== 8'd0)
            $display("[TB] FAIL rmid_new got valid=%0b data=%h idx=%0d exp 1/3f800000/0", out_valid, out_data, out_idx_hi); else passed++;
        consume();
    endtask

    task automatic test_nan();
        logic [31:0] exp_data;
`ifdef FP_ABSMAX_NAN_EN
        exp_data = 32'h7FC0_0000;
`else
        exp_data = 32'h7FA0_0001;
`endif
        send_beat(FP32, 32'h7F80_0000, 1'b0);
        send_beat(FP32, 32'h7FA0_0001, 1'b0);
        send_beat(FP32, 32'h7F80_0001, 1'b1);
        total++; if (out_data !== exp_data) $display("[TB] FAIL nan_data got %h exp %h", out_data, exp_data); else passed++;
        total++; if (out_idx_hi !== 8'd1) $display("[TB] FAIL nan_idx got %0d exp 1", out_idx_hi); else passed++;
        consume();
    endtask

    initial begin
        test_reset();
        test_fp32_max();
        test_fp16_lanes();
        test_tie();
        test_back_to_back();
        test_fmt_err_ovf();
        test_reset_mid();
        test_nan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
